bus_mem: RTL
============

// Module: bus_mem
// PURPOSE
//  Parametrised synthesizable memory slave for the core's m_* byte bus.
//  Replaces ad-hoc bench memory arrays. Adds programmable wait states, address mirroring,
//  out-of-range detection and an optional backdoor loader.
//  Sits between core and bench/top; port names match the core side so the two wire 1:1.
// PARAMETERS
//  ADDR_W       16     bus address width
//  DATA_W       8      data width
//  DEPTH        16     number of words; must be a power of two when MIRROR=1
//  WAIT_CYCLES  0      stall cycles inserted per access (0..255)
//  MIRROR       1      1: index = addr mod DEPTH; 0: addr>=DEPTH is out of range
//  FILL         8'hFF  read data returned for an out-of-range address
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous, active-low reset
//  m_req      in   1       access request, held stable by core while m_wait=1
//  m_wr       in   1       1=write, 0=read
//  m_addr     in   ADDR_W  access address
//  m_outdata  in   DATA_W  write data from core
//  m_indata   out  DATA_W  registered read data
//  m_wait     out  1       stall; combinational from state/m_req/ld_we
//  m_err      out  1       one-cycle pulse after an out-of-range access
//  ld_we      in   1       loader write strobe (MEM_LOADER_EN only)
//  ld_addr    in   ADDR_W  loader address, indexed like m_addr (MEM_LOADER_EN only)
//  ld_data    in   DATA_W  loader data (MEM_LOADER_EN only)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE, cnt=0, m_indata=0, m_err=0; any pending access is dropped
//    and no write occurs. Memory contents are not cleared.
//  - FSM states IDLE and BUSY; cnt is 8 bits.
//  - IDLE, m_req=1, WAIT_CYCLES=0: access at this edge; m_wait=0; stay IDLE.
//  - IDLE, m_req=1, WAIT_CYCLES>0: m_wait=1 this cycle; latch addr/wr/wdata; cnt<=WAIT_CYCLES-1; ->BUSY.
//  - BUSY, cnt!=0: m_wait=1; cnt<=cnt-1.
//  - BUSY, cnt==0: m_wait=0; access at this edge using the latched values; ->IDLE.
//  - Each access stalls exactly WAIT_CYCLES cycles. The access completes on the edge where m_wait=0.
//  - Read: m_indata<=mem[idx] at the access edge. Between accesses and on writes, m_indata holds.
//  - Write: mem[idx]<=wdata at the access edge.
//  - Out of range (MIRROR=0 and addr>=DEPTH): a read loads FILL and a write is discarded.
//    m_err=1 for the cycle after the access edge, otherwise 0. With MIRROR=1, m_err is always 0.
//  - Index is addr[$clog2(DEPTH)-1:0] when MIRROR=1. High address bits are ignored.
//  - m_req=0 in IDLE: no state change, m_wait=0.
//  - m_req dropping while BUSY is a protocol violation; the access still completes.
//  - Back-to-back accesses: a new request is accepted in the IDLE cycle directly after completion.
// CONFIGURATION
//  MEM_LOADER_EN defined:
//  - ld_* ports exist. ld_we=1 writes mem[ld_addr]<=ld_data at posedge, with priority over the bus.
//  - Loader writes are honoured even while rst=0, which allows preload under reset.
//  - If ld_we=1 on a cycle that would be a bus access edge (IDLE with WAIT=0, or BUSY with cnt==0):
//    m_wait=1, the bus access is deferred one cycle, and state/cnt are unchanged.
//  - A deferred read of the loaded address returns the new data.
//  MEM_LOADER_EN undefined:
//  - ld_* ports are absent and there is no deferral logic.
//  - Contents are undefined (X in simulation) until written over the bus.
// TESTING
//  T1 WAIT=0, load mem[0]=0x10 under reset, release, read addr 0
//     -> m_indata=0x10 one edge later; m_wait never 1.
//  T2 WAIT=2, read addr 3 (holds 0x55)
//     -> m_wait=1 for 2 cycles; m_indata=0x55 after the 3rd edge.
//  T3 WAIT=1, write 0xAA @5, then read @5
//     -> m_indata=0xAA; m_indata unchanged across the write.
//  T4 DEPTH=16, MIRROR=1: read 0x0013 -> value of cell 3, m_err=0.
//     MIRROR=0: read 0x0013 -> m_indata=0xFF with m_err pulse; a write to 0x0013 leaves all cells unchanged.
//  T5 WAIT=3, write 0x77 @2 (cell holds 0x11), rst=0 during BUSY
//     -> cell 2 still 0x11; m_wait=0, m_indata=0, state IDLE.
//  T6 WAIT=0, ld_we writes 0x42 @4 on the same cycle as a read @4
//     -> m_wait=1 that cycle; next edge m_indata=0x42.

Source files
------------

// File: rtl/bus_mem.sv
// Byte-bus memory slave with programmable wait states, address mirroring and out-of-range fill.
// Define MEM_LOADER_EN to add the ld_* backdoor loader, which has priority over bus accesses.
module bus_mem #(
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 8,
  parameter int              DEPTH       = 16,
  parameter int              WAIT_CYCLES = 0,
  parameter int              MIRROR      = 1,
  parameter logic [DATA_W-1:0] FILL      = DATA_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              m_wr,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_outdata,
  output logic [DATA_W-1:0] m_indata,
  output logic              m_wait,
  output logic              m_err
`ifdef MEM_LOADER_EN
  ,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]        WAIT_M1 = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wr;
  logic [DATA_W-1:0] lat_wdata;

  logic              ld_hold;
  logic              due, acc;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

`ifdef MEM_LOADER_EN
  logic             ld_wr;
  logic [IDX_W-1:0] ld_idx;
  assign ld_hold = ld_we;
  // Loader addresses follow the bus rules: mirrored, or dropped when out of range.
  assign ld_wr   = ld_we && ((MIRROR != 0) || (ld_addr < DEPTH_A));
  assign ld_idx  = ld_addr[IDX_W-1:0];
`else
  assign ld_hold = 1'b0;
`endif

  // 'due' marks an access edge; a loader write on that edge pushes the access out one cycle.
  assign due = ((state == IDLE) && m_req && (WAIT_CYCLES == 0)) ||
               ((state == BUSY) && (cnt == 8'd0));
  assign acc = due && !ld_hold;

  assign m_wait = ((state == IDLE) && m_req && (WAIT_CYCLES != 0)) ||
                  ((state == BUSY) && (cnt != 8'd0)) ||
                  (due && ld_hold);

  assign acc_addr  = (state == BUSY) ? lat_addr  : m_addr;
  assign acc_wr    = (state == BUSY) ? lat_wr    : m_wr;
  assign acc_wdata = (state == BUSY) ? lat_wdata : m_outdata;
  assign in_range  = (MIRROR != 0) || (acc_addr < DEPTH_A);
  assign idx       = acc_addr[IDX_W-1:0];

  // Storage has no reset so contents survive rst and can be preloaded under reset.
  always_ff @(posedge clk) begin
`ifdef MEM_LOADER_EN
    if (ld_wr)
      mem[ld_idx] <= ld_data;
    else
`endif
    if (rst && acc && acc_wr && in_range)
      mem[idx] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      m_indata  <= '0;
      m_err     <= 1'b0;
      lat_addr  <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      m_err <= 1'b0;
      if (acc) begin
        if (!acc_wr) m_indata <= in_range ? mem[idx] : FILL;
        m_err <= !in_range;
      end
      case (state)
        IDLE: begin
          if (m_req && (WAIT_CYCLES != 0)) begin
            lat_addr  <= m_addr;
            lat_wr    <= m_wr;
            lat_wdata <= m_outdata;
            cnt       <= WAIT_M1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else if (!ld_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
